// File: rtl/demux_tdm4_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexer.
// Slot numbering matches the transmit-side 4:1 mux select encoding.
package demux_tdm4_pkg;

    localparam int WIDTH = 4;
    localparam int SLOTS = 4;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef logic [WIDTH-1:0] sample_t;

    typedef struct packed {
        logic    sync;
        sample_t data;
    } beat_t;

    function automatic logic [1:0] slot_inc(input logic [1:0] slot);
        return slot + 2'd1;
    endfunction

endpackage

// File: rtl/demux_tdm4_if.sv
// Link-side and frame-side signals of the TDM receiver.
// master drives the serial link; slave is the demultiplexer.
interface demux_tdm4_if;
    import demux_tdm4_pkg::*;

    logic       in_valid;
    logic       in_sync;
    sample_t    din;
    sample_t    a;
    sample_t    b;
    sample_t    c;
    sample_t    d;
    logic       out_valid;
    logic [1:0] s;
    logic       locked;
    logic       sync_err;

    modport master (
        output in_valid, in_sync, din,
        input  a, b, c, d, out_valid, s, locked, sync_err
    );

    modport slave (
        input  in_valid, in_sync, din,
        output a, b, c, d, out_valid, s, locked, sync_err
    );

endinterface

// File: rtl/demux_tdm4_dec2_4.sv
// Gate-level 2-to-4 decoder with enable: one-hot per-slot write strobes.
// Mirror image of the transmit 4:1 mux select tree.
module demux_tdm4_dec2_4 (
    input  logic [1:0] i_sel,
    input  logic       i_en,
    output logic [3:0] o_y
);

    logic w_ns0;
    logic w_ns1;

    not u_n0 (w_ns0, i_sel[0]);
    not u_n1 (w_ns1, i_sel[1]);

    and u_a0 (o_y[0], i_en, w_ns1,    w_ns0);
    and u_a1 (o_y[1], i_en, w_ns1,    i_sel[0]);
    and u_a2 (o_y[2], i_en, i_sel[1], w_ns0);
    and u_a3 (o_y[3], i_en, i_sel[1], i_sel[0]);

endmodule

// File: rtl/demux_tdm4.sv
// 4-slot TDM frame receiver: hunts for the slot-0 sync, gathers slots into
// shadow registers and publishes whole frames with a one-cycle out_valid.
module demux_tdm4
    import demux_tdm4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    demux_tdm4_if.slave  bus
);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [1:0]                   r_s;
    logic [1:0]                   w_s_nxt;
    logic                         r_out_valid;
    logic                         w_out_valid_nxt;
    logic                         r_sync_err;
    logic                         w_sync_err_nxt;

    logic [SLOTS-2:0][WIDTH-1:0]  r_shadow;
    logic [SLOTS-1:0][WIDTH-1:0]  r_frame;

    logic                         w_dec_en;
    logic [SLOTS-1:0]             w_we;
    logic                         w_sync;
    logic [SLOTS-2:0]             w_ld_sh;
    logic                         w_ld_out;

    assign w_dec_en = bus.in_valid & (r_state == ST_LOCKED);
    assign w_sync   = bus.in_valid & bus.in_sync;

    demux_tdm4_dec2_4 u_dec (
        .i_sel (r_s),
        .i_en  (w_dec_en),
        .o_y   (w_we)
    );

    // A sync always restarts the frame at slot 0, in HUNT or mid-frame.
    assign w_ld_sh[0] = w_sync | w_we[0];
    assign w_ld_sh[1] = w_we[1] & ~bus.in_sync;
    assign w_ld_sh[2] = w_we[2] & ~bus.in_sync;
    assign w_ld_out   = w_we[3] & ~bus.in_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_s         <= SLOT_A;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_sync_err  <= w_sync_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_out_valid_nxt = 1'b0;
        w_sync_err_nxt  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_sync) begin
                    w_state_nxt = ST_LOCKED;
                    w_s_nxt     = SLOT_B;
                end
            end
            ST_LOCKED: begin
                if (bus.in_valid) begin
                    if (bus.in_sync) begin
                        w_s_nxt        = SLOT_B;
                        w_sync_err_nxt = (r_s != SLOT_A);
                    end else begin
                        w_s_nxt         = slot_inc(r_s);
                        w_out_valid_nxt = (r_s == SLOT_D);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
                w_s_nxt     = SLOT_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_frame  <= '0;
        end else begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                if (w_ld_sh[i]) begin
                    r_shadow[i] <= bus.din;
                end
            end
            if (w_ld_out) begin
                r_frame <= {bus.din, r_shadow[2], r_shadow[1], r_shadow[0]};
            end
        end
    end

    assign bus.a         = r_frame[SLOT_A];
    assign bus.b         = r_frame[SLOT_B];
    assign bus.c         = r_frame[SLOT_C];
    assign bus.d         = r_frame[SLOT_D];
    assign bus.out_valid = r_out_valid;
    assign bus.sync_err  = r_sync_err;
    assign bus.s         = r_s;
    assign bus.locked    = (r_state == ST_LOCKED);

endmodule
